// File: rtl/ctrl_pipe_hazard_if.sv
// rtl/ctrl_pipe_hazard_if.sv - decoder/datapath <-> pipeline-control bundle
interface ctrl_pipe_hazard_if #(
    parameter int RA_W  = 5,
    parameter int AOP_W = 2
);
    logic             id_reg_dst;
    logic             id_reg_write;
    logic             id_alu_src;
    logic             id_mem_read;
    logic             id_mem_write;
    logic             id_mem_to_reg;
    logic             id_sel_pc;
    logic             id_branch;
    logic             id_branch_not;
    logic [AOP_W-1:0] id_alu_op;
    logic [RA_W-1:0]  id_rs;
    logic [RA_W-1:0]  id_rt;
    logic [RA_W-1:0]  id_rd;
    logic             ex_zero;

    logic             ex_reg_dst;
    logic             ex_alu_src;
    logic             ex_branch;
    logic             ex_branch_not;
    logic [AOP_W-1:0] ex_alu_op;
    logic             mem_mem_read;
    logic             mem_mem_write;
    logic             wb_reg_write;
    logic             wb_mem_to_reg;
    logic [RA_W-1:0]  wb_dst;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             pc_src_branch;

    modport master (
        output id_reg_dst, id_reg_write, id_alu_src, id_mem_read, id_mem_write,
               id_mem_to_reg, id_sel_pc, id_branch, id_branch_not, id_alu_op,
               id_rs, id_rt, id_rd, ex_zero,
        input  ex_reg_dst, ex_alu_src, ex_branch, ex_branch_not, ex_alu_op,
               mem_mem_read, mem_mem_write, wb_reg_write, wb_mem_to_reg, wb_dst,
               fwd_a, fwd_b, pc_write, ifid_write, ifid_flush, pc_src_branch
    );

    modport slave (
        input  id_reg_dst, id_reg_write, id_alu_src, id_mem_read, id_mem_write,
               id_mem_to_reg, id_sel_pc, id_branch, id_branch_not, id_alu_op,
               id_rs, id_rt, id_rd, ex_zero,
        output ex_reg_dst, ex_alu_src, ex_branch, ex_branch_not, ex_alu_op,
               mem_mem_read, mem_mem_write, wb_reg_write, wb_mem_to_reg, wb_dst,
               fwd_a, fwd_b, pc_write, ifid_write, ifid_flush, pc_src_branch
    );
endinterface

// File: rtl/ctrl_pipe_hazard.sv
// rtl/ctrl_pipe_hazard.sv - MIPS control pipeline, stalls, flushes, forwarding
// CTRL_PIPE_FORWARDING_EN: defined = EX forwarding; undefined = stall on any RAW.
module ctrl_pipe_hazard #(
    parameter int RA_W  = 5,
    parameter int AOP_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    ctrl_pipe_hazard_if.slave  bus
);
    logic             ex_reg_dst_q, ex_reg_write_q, ex_alu_src_q, ex_mem_read_q;
    logic             ex_mem_write_q, ex_mem_to_reg_q, ex_branch_q, ex_branch_not_q;
    logic [AOP_W-1:0] ex_alu_op_q;
    logic [RA_W-1:0]  ex_rt_q, ex_rd_q;
    logic             mem_reg_write_q, mem_mem_read_q, mem_mem_write_q, mem_mem_to_reg_q;
    logic [RA_W-1:0]  mem_dst_q;
    logic             wb_reg_write_q, wb_mem_to_reg_q;
    logic [RA_W-1:0]  wb_dst_q;
`ifdef CTRL_PIPE_FORWARDING_EN
    logic [RA_W-1:0]  ex_rs_q;
`endif

    logic [RA_W-1:0]  ex_dst;
    logic             load_use, hazard, taken, stall, bubble;

    assign ex_dst   = ex_reg_dst_q ? ex_rd_q : ex_rt_q;
    assign load_use = ex_mem_read_q && (ex_rt_q != '0) &&
                      ((ex_rt_q == bus.id_rs) || (ex_rt_q == bus.id_rt));

`ifdef CTRL_PIPE_FORWARDING_EN
    function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] src);
        if (mem_reg_write_q && (mem_dst_q != '0) && (mem_dst_q == src))
            return 2'b10;
        else if (wb_reg_write_q && (wb_dst_q != '0) && (wb_dst_q == src))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign hazard    = load_use;
    assign bus.fwd_a = fwd_sel(ex_rs_q);
    assign bus.fwd_b = fwd_sel(ex_rt_q);
`else
    // Without bypass paths, any producer still in EX or MEM must retire first.
    function automatic logic raw_hit(input logic [RA_W-1:0] src);
        return (src != '0) &&
               ((ex_reg_write_q && (ex_dst == src)) ||
                (mem_reg_write_q && (mem_dst_q == src)));
    endfunction

    assign hazard    = load_use || raw_hit(bus.id_rs) || raw_hit(bus.id_rt);
    assign bus.fwd_a = 2'b00;
    assign bus.fwd_b = 2'b00;
`endif

    assign taken  = (ex_branch_q && bus.ex_zero) || (ex_branch_not_q && !bus.ex_zero);
    assign stall  = hazard && !taken;
    assign bubble = stall || taken;

    always_comb begin
        bus.pc_write      = 1'b1;
        bus.ifid_write    = 1'b1;
        bus.ifid_flush    = 1'b0;
        bus.pc_src_branch = 1'b0;
        if (!rst) begin
            bus.pc_write      = !stall;
            bus.ifid_write    = !stall;
            bus.ifid_flush    = taken || bus.id_sel_pc;
            bus.pc_src_branch = taken;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_reg_dst_q     <= 1'b0;
            ex_reg_write_q   <= 1'b0;
            ex_alu_src_q     <= 1'b0;
            ex_mem_read_q    <= 1'b0;
            ex_mem_write_q   <= 1'b0;
            ex_mem_to_reg_q  <= 1'b0;
            ex_branch_q      <= 1'b0;
            ex_branch_not_q  <= 1'b0;
            ex_alu_op_q      <= '0;
            ex_rt_q          <= '0;
            ex_rd_q          <= '0;
            mem_reg_write_q  <= 1'b0;
            mem_mem_read_q   <= 1'b0;
            mem_mem_write_q  <= 1'b0;
            mem_mem_to_reg_q <= 1'b0;
            mem_dst_q        <= '0;
            wb_reg_write_q   <= 1'b0;
            wb_mem_to_reg_q  <= 1'b0;
            wb_dst_q         <= '0;
`ifdef CTRL_PIPE_FORWARDING_EN
            ex_rs_q          <= '0;
`endif
        end else begin
            ex_reg_dst_q     <= bubble ? 1'b0 : bus.id_reg_dst;
            ex_reg_write_q   <= bubble ? 1'b0 : bus.id_reg_write;
            ex_alu_src_q     <= bubble ? 1'b0 : bus.id_alu_src;
            ex_mem_read_q    <= bubble ? 1'b0 : bus.id_mem_read;
            ex_mem_write_q   <= bubble ? 1'b0 : bus.id_mem_write;
            ex_mem_to_reg_q  <= bubble ? 1'b0 : bus.id_mem_to_reg;
            ex_branch_q      <= bubble ? 1'b0 : bus.id_branch;
            ex_branch_not_q  <= bubble ? 1'b0 : bus.id_branch_not;
            ex_alu_op_q      <= bubble ? '0   : bus.id_alu_op;
            ex_rt_q          <= bus.id_rt;
            ex_rd_q          <= bus.id_rd;
`ifdef CTRL_PIPE_FORWARDING_EN
            ex_rs_q          <= bus.id_rs;
`endif
            mem_reg_write_q  <= ex_reg_write_q;
            mem_mem_read_q   <= ex_mem_read_q;
            mem_mem_write_q  <= ex_mem_write_q;
            mem_mem_to_reg_q <= ex_mem_to_reg_q;
            mem_dst_q        <= ex_dst;
            wb_reg_write_q   <= mem_reg_write_q;
            wb_mem_to_reg_q  <= mem_mem_to_reg_q;
            wb_dst_q         <= mem_dst_q;
        end
    end

    assign bus.ex_reg_dst    = ex_reg_dst_q;
    assign bus.ex_alu_src    = ex_alu_src_q;
    assign bus.ex_branch     = ex_branch_q;
    assign bus.ex_branch_not = ex_branch_not_q;
    assign bus.ex_alu_op     = ex_alu_op_q;
    assign bus.mem_mem_read  = mem_mem_read_q;
    assign bus.mem_mem_write = mem_mem_write_q;
    assign bus.wb_reg_write  = wb_reg_write_q;
    assign bus.wb_mem_to_reg = wb_mem_to_reg_q;
    assign bus.wb_dst        = wb_dst_q;
endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// tb/tb_ctrl_pipe_hazard.sv - directed self-checking bench for ctrl_pipe_hazard
module tb_ctrl_pipe_hazard;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    ctrl_pipe_hazard_if #(.RA_W(5), .AOP_W(2)) bus ();

    ctrl_pipe_hazard #(.RA_W(5), .AOP_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_id(input logic rdst, input logic rw, input logic as, input logic mr,
                          input logic mw, input logic m2r, input logic spc, input logic br,
                          input logic brn, input logic [1:0] aop,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        bus.id_reg_dst    = rdst;
        bus.id_reg_write  = rw;
        bus.id_alu_src    = as;
        bus.id_mem_read   = mr;
        bus.id_mem_write  = mw;
        bus.id_mem_to_reg = m2r;
        bus.id_sel_pc     = spc;
        bus.id_branch     = br;
        bus.id_branch_not = brn;
        bus.id_alu_op     = aop;
        bus.id_rs         = rs;
        bus.id_rt         = rt;
        bus.id_rd         = rd;
    endtask

    task automatic nop();                                   set_id(0,0,0,0,0,0,0,0,0,2'b00,0,0,0);   endtask
    task automatic r_type(input logic [4:0] rs, rt, rd);    set_id(1,1,0,0,0,0,0,0,0,2'b10,rs,rt,rd); endtask
    task automatic lw(input logic [4:0] rs, rt);            set_id(0,1,1,1,0,1,0,0,0,2'b00,rs,rt,0);  endtask
    task automatic addi(input logic [4:0] rs, rt);          set_id(0,1,1,0,0,0,0,0,0,2'b00,rs,rt,0);  endtask
    task automatic beq(input logic [4:0] rs, rt);           set_id(0,0,0,0,0,0,0,1,0,2'b01,rs,rt,0);  endtask
    task automatic bne(input logic [4:0] rs, rt);           set_id(0,0,0,0,0,0,0,0,1,2'b01,rs,rt,0);  endtask
    task automatic jmp();                                   set_id(0,0,0,0,0,0,1,0,0,2'b00,0,0,0);   endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drain();
        nop();
        bus.ex_zero = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        bus.ex_zero = 1'b0;
        nop();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sample();
        check("rst_pc_write",   bus.pc_write,      1);
        check("rst_ifid_write", bus.ifid_write,    1);
        check("rst_ifid_flush", bus.ifid_flush,    0);
        check("rst_pc_src",     bus.pc_src_branch, 0);
        check("rst_fwd_a",      bus.fwd_a,         0);
        check("rst_fwd_b",      bus.fwd_b,         0);
        check("rst_ex_alu_op",  bus.ex_alu_op,     0);
        check("rst_wb_rw",      bus.wb_reg_write,  0);
        check("rst_wb_dst",     bus.wb_dst,        0);
        check("rst_mem_read",   bus.mem_mem_read,  0);

        // plain propagation of add $3,$1,$2 through the pipeline
        step(); r_type(1, 2, 3); step(); nop(); sample();
        check("prop_ex_reg_dst", bus.ex_reg_dst, 1);
        check("prop_ex_alu_op",  bus.ex_alu_op,  2);
        step(); step(); sample();
        check("prop_wb_rw",  bus.wb_reg_write,  1);
        check("prop_wb_dst", bus.wb_dst,        3);
        check("prop_wb_m2r", bus.wb_mem_to_reg, 0);
        drain();

`ifdef CTRL_PIPE_FORWARDING_EN
        r_type(1, 2, 3); step(); r_type(3, 5, 4); sample();
        check("chain_no_stall", bus.pc_write, 1);
        step(); nop(); sample();
        check("chain_fwd_a_mem", bus.fwd_a, 2'b10);
        check("chain_fwd_b_rf",  bus.fwd_b, 2'b00);
        drain();

        r_type(1, 2, 3); step(); nop(); step(); r_type(3, 5, 4); step(); nop(); sample();
        check("gap_fwd_a_wb", bus.fwd_a, 2'b01);
        check("gap_fwd_b_rf", bus.fwd_b, 2'b00);
        drain();

        r_type(1, 2, 3); step(); r_type(1, 2, 3); step(); r_type(3, 3, 4); step(); nop(); sample();
        check("prio_fwd_a", bus.fwd_a, 2'b10);
        check("prio_fwd_b", bus.fwd_b, 2'b10);
        drain();

        lw(1, 8); step(); r_type(8, 2, 9); sample();
        check("lu_pc_write",   bus.pc_write,   0);
        check("lu_ifid_write", bus.ifid_write, 0);
        step(); sample();
        check("lu_release",    bus.pc_write,     1);
        check("lu_bubble_op",  bus.ex_alu_op,    0);
        check("lu_bubble_src", bus.ex_alu_src,   0);
        check("lu_mem_read",   bus.mem_mem_read, 1);
        step(); nop(); sample();
        check("lu_fwd_a_wb", bus.fwd_a,         2'b01);
        check("lu_wb_m2r",   bus.wb_mem_to_reg, 1);
        drain();
`else
        r_type(1, 2, 3); step(); r_type(3, 5, 4); sample();
        check("raw_ex_pc_write",   bus.pc_write,   0);
        check("raw_ex_ifid_write", bus.ifid_write, 0);
        step(); sample();
        check("raw_mem_pc_write", bus.pc_write,  0);
        check("raw_bubble_op",    bus.ex_alu_op, 0);
        step(); sample();
        check("raw_release", bus.pc_write, 1);
        step(); nop(); sample();
        check("raw_sub_in_ex", bus.ex_alu_op, 2);
        check("raw_fwd_a_tied", bus.fwd_a,    0);
        drain();

        lw(1, 8); step(); r_type(8, 2, 9); sample();
        check("lu_pc_write_1", bus.pc_write, 0);
        step(); sample();
        check("lu_pc_write_2", bus.pc_write,   0);
        check("lu_bubble_src", bus.ex_alu_src, 0);
        step(); sample();
        check("lu_release", bus.pc_write,      1);
        check("lu_wb_m2r",  bus.wb_mem_to_reg, 1);
        step(); nop(); sample();
        check("lu_add_in_ex", bus.ex_alu_op, 2);
        drain();
`endif

        beq(1, 2); step(); r_type(6, 7, 10); bus.ex_zero = 1'b1; sample();
        check("beq_pc_src",   bus.pc_src_branch, 1);
        check("beq_flush",    bus.ifid_flush,    1);
        check("beq_pc_write", bus.pc_write,      1);
        check("beq_ex_br",    bus.ex_branch,     1);
        step(); nop(); bus.ex_zero = 1'b0; sample();
        check("beq_bubble_dst", bus.ex_reg_dst,    0);
        check("beq_bubble_op",  bus.ex_alu_op,     0);
        check("beq_after_src",  bus.pc_src_branch, 0);
        check("beq_after_fl",   bus.ifid_flush,    0);
        drain();

        bne(1, 2); step(); nop(); bus.ex_zero = 1'b1; sample();
        check("bne_ex_brn",   bus.ex_branch_not, 1);
        check("bne_z1_src",   bus.pc_src_branch, 0);
        check("bne_z1_flush", bus.ifid_flush,    0);
        bus.ex_zero = 1'b0; #1;
        check("bne_z0_src", bus.pc_src_branch, 1);
        drain();

        beq(1, 2); step(); jmp(); bus.ex_zero = 1'b1; sample();
        check("jb_flush",      bus.ifid_flush,    1);
        check("jb_pc_src",     bus.pc_src_branch, 1);
        check("jb_pc_write",   bus.pc_write,      1);
        check("jb_ifid_write", bus.ifid_write,    1);
        drain();

        // artificial EX bundle that is both a load and a taken branch
        set_id(0,0,0,1,0,0,0,1,0,2'b01,1,8,0); step(); r_type(8, 2, 9); bus.ex_zero = 1'b1; sample();
        check("blu_pc_write",   bus.pc_write,   1);
        check("blu_ifid_write", bus.ifid_write, 1);
        check("blu_flush",      bus.ifid_flush, 1);
        step(); nop(); bus.ex_zero = 1'b0; sample();
        check("blu_bubble_op", bus.ex_alu_op, 0);
        check("blu_no_stall",  bus.pc_write,  1);
        drain();

        jmp(); sample();
        check("j_flush",    bus.ifid_flush, 1);
        check("j_pc_write", bus.pc_write,   1);
        step(); nop(); sample();
        check("j_after_flush", bus.ifid_flush, 0);
        check("j_ex_branch",   bus.ex_branch,  0);
        drain();

        addi(0, 0); step(); r_type(0, 0, 5); sample();
        check("r0_no_stall", bus.pc_write, 1);
        step(); nop(); sample();
        check("r0_fwd_a", bus.fwd_a, 0);
        check("r0_fwd_b", bus.fwd_b, 0);
        drain();

        lw(1, 8); step(); r_type(8, 2, 9); sample();
        check("mid_stall", bus.pc_write, 0);
        rst = 1'b1; step(); rst = 1'b0; sample();
        check("mid_pc_write",   bus.pc_write,     1);
        check("mid_ifid_write", bus.ifid_write,   1);
        check("mid_mem_read",   bus.mem_mem_read, 0);
        check("mid_ex_src",     bus.ex_alu_src,   0);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
